// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: NBANK banks of four digits scanned in
// parallel, with tear-free frame-aligned data update, leading-zero blanking and PWM dimming.
module seg_scan_ctrl #(
  parameter int DIGITS  = 8,
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [4*DIGITS-1:0] hex_data,
  input  logic [DIGITS-1:0]   dp,
  input  logic                load,
  input  logic                lz_blank,
  input  logic                enable,
  input  logic [3:0]          brightness,
  output logic [2*DIGITS-1:0] seg,
  output logic [DIGITS-1:0]   sel,
  output logic                frame_done
);

  localparam int NBANK = DIGITS / 4;
  localparam int SLOT  = CLK_HZ / (SCAN_HZ * 4);
  localparam int CNT_W = $clog2(SLOT);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT - 1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0]    slot_cnt_q, slot_cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_hex_q, pend_hex_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_valid_q, pend_valid_d;
  logic [4*DIGITS-1:0] disp_hex_q, disp_hex_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [2*DIGITS-1:0] seg_q, seg_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                frame_done_q, frame_done_d;

  logic                slot_wrap;
  logic                frame_wrap;
  logic                zero_run;
  logic [DIGITS-1:0]   lz_mask;
  logic [7:0]          digit_seg [DIGITS];
  logic [31:0]         pwm_limit;
  logic                pwm_on;

  always_comb begin
    slot_wrap    = (slot_cnt_q == SLOT_LAST);
    frame_wrap   = slot_wrap && (idx_q == 2'd3);
    slot_cnt_d   = slot_wrap ? '0 : slot_cnt_q + CNT_W'(1);
    idx_d        = slot_wrap ? idx_q + 2'd1 : idx_q;
    frame_done_d = frame_wrap;
  end

  // A load on the wrap cycle lands in pending after the older pending value
  // has been committed, so neither value is lost.
  always_comb begin
    pend_hex_d   = pend_hex_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    disp_hex_d   = disp_hex_q;
    disp_dp_d    = disp_dp_q;
    if (frame_wrap) begin
      pend_valid_d = 1'b0;
      if (pend_valid_q) begin
        disp_hex_d = pend_hex_q;
        disp_dp_d  = pend_dp_q;
      end
    end
    if (load) begin
      pend_hex_d   = hex_data;
      pend_dp_d    = dp;
      pend_valid_d = 1'b1;
    end
  end

  // Zero run is tracked from the most significant digit down across all banks.
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_run   = zero_run && (disp_hex_q[4*k +: 4] == 4'h0);
      lz_mask[k] = zero_run;
    end
  end

  always_comb begin
    for (int k = 0; k < DIGITS; k++) begin
      digit_seg[k] = {disp_dp_q[k],
                      (lz_blank && lz_mask[k]) ? 7'h00 : hex_to_seg(disp_hex_q[4*k +: 4])};
    end
  end

  always_comb begin
    pwm_limit = ((32'(brightness) + 32'd1) * 32'(SLOT)) >> 4;
    pwm_on    = enable && (32'(slot_cnt_q) < pwm_limit);
    seg_d     = '0;
    sel_d     = '0;
    for (int b = 0; b < NBANK; b++) begin
      for (int i = 0; i < 4; i++) begin
        if (idx_q == 2'(i)) begin
          seg_d[8*b +: 8]  = digit_seg[4*b + i];
          sel_d[4*b + i]   = pwm_on;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt_q   <= '0;
      idx_q        <= '0;
      pend_hex_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      disp_hex_q   <= '0;
      disp_dp_q    <= '0;
      seg_q        <= '0;
      sel_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      idx_q        <= idx_d;
      pend_hex_q   <= pend_hex_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      disp_hex_q   <= disp_hex_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign sel        = sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus random traffic,
// compared every cycle against a frame-level behavioural model.
module tb_seg_scan_ctrl;

  localparam int DIGITS  = 8;
  localparam int CLK_HZ  = 6400;
  localparam int SCAN_HZ = 100;
  localparam int SLOT    = 16;

  logic          clk;
  logic          reset_n;
  logic [31:0]   hex_data;
  logic [7:0]    dp;
  logic          load;
  logic          lz_blank;
  logic          enable;
  logic [3:0]    brightness;
  logic [15:0]   seg;
  logic [7:0]    sel;
  logic          frame_done;

  int checks;
  int failures;

  // Model state: cycle count since reset release plus pending/display words.
  int          cyc;
  logic [31:0] mPend, mDisp;
  logic [7:0]  mPendDp, mDispDp;
  logic        mValid;
  logic [15:0] expSeg;
  logic [7:0]  expSel;
  logic        expFd;

  logic [6:0] segTab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg_scan_ctrl #(
    .DIGITS  (DIGITS),
    .CLK_HZ  (CLK_HZ),
    .SCAN_HZ (SCAN_HZ)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .hex_data   (hex_data),
    .dp         (dp),
    .load       (load),
    .lz_blank   (lz_blank),
    .enable     (enable),
    .brightness (brightness),
    .seg        (seg),
    .sel        (sel),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic modelReset();
    cyc     = 0;
    mPend   = '0;
    mDisp   = '0;
    mPendDp = '0;
    mDispDp = '0;
    mValid  = 1'b0;
    expSeg  = '0;
    expSel  = '0;
    expFd   = 1'b0;
  endtask

  // Outputs after an edge describe the digit slot that was current before it.
  task automatic modelEdge();
    int          idx;
    int          slot;
    int          k;
    logic [31:0] sh;
    logic [7:0]  dsh;
    logic [7:0]  segByte;
    idx    = (cyc / SLOT) % 4;
    slot   = cyc % SLOT;
    expSeg = '0;
    for (int b = 0; b < 2; b++) begin
      k   = 4 * b + idx;
      sh  = mDisp >> (4 * k);
      dsh = mDispDp >> k;
      segByte = {dsh[0], (lz_blank && k > 0 && sh == 0) ? 7'h00 : segTab[sh[3:0]]};
      expSeg  = expSeg | (16'(segByte) << (8 * b));
    end
    if (enable && slot < (((int'(brightness) + 1) * SLOT) >> 4))
      expSel = 8'h11 << idx;
    else
      expSel = 8'h00;
    expFd = (cyc % (4 * SLOT)) == (4 * SLOT - 1);
    if (expFd && mValid) begin
      mDisp   = mPend;
      mDispDp = mPendDp;
    end
    if (expFd) mValid = 1'b0;
    if (load) begin
      mPend   = hex_data;
      mPendDp = dp;
      mValid  = 1'b1;
    end
    cyc++;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".seg"}, 32'(seg), 32'(expSeg));
    checkVal({tag, ".sel"}, 32'(sel), 32'(expSel));
    checkVal({tag, ".frame_done"}, 32'(frame_done), 32'(expFd));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (reset_n) modelEdge();
    #1 checkOutput(tag);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [31:0] data, input logic [7:0] dpv, input string tag);
    hex_data = data;
    dp       = dpv;
    load     = 1'b1;
    tick(tag);
    load     = 1'b0;
  endtask

  task automatic runCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic runToPhase(input int phase, input string tag);
    for (int i = 0; i < 4 * SLOT && (cyc % (4 * SLOT)) != phase; i++) tick(tag);
  endtask

  initial begin
    int onCount;
    checks     = 0;
    failures   = 0;
    reset_n    = 1'b0;
    hex_data   = '0;
    dp         = '0;
    load       = 1'b0;
    lz_blank   = 1'b0;
    enable     = 1'b1;
    brightness = 4'd15;
    modelReset();
    @(negedge clk);
    runCycles(3, "reset");

    $display("[TB] power-on scan");
    reset_n = 1'b1;
    runCycles(2 * 4 * SLOT, "poweron");

    $display("[TB] load mid-frame");
    runToPhase(20, "load_align");
    applyStimulus(32'h1234ABCD, 8'h00, "load");
    runCycles(2 * 4 * SLOT, "load_frame");

    $display("[TB] leading-zero blanking");
    lz_blank = 1'b1;
    applyStimulus(32'h00000A05, 8'h20, "lz");
    runCycles(2 * 4 * SLOT, "lz_frame");

    $display("[TB] pwm and enable");
    brightness = 4'd7;
    runCycles(3, "pwm_settle");
    onCount = 0;
    for (int i = 0; i < SLOT; i++) begin
      tick("pwm");
      if (sel != 8'h00) onCount++;
    end
    checkVal("pwm_on_count", 32'(onCount), 32'd8);
    runCycles(4 * SLOT, "pwm_frame");
    enable = 1'b0;
    tick("enable_off");
    checkVal("enable_off_sel", 32'(sel), 32'd0);
    runCycles(4 * SLOT, "disabled");
    enable     = 1'b1;
    brightness = 4'd0;
    runCycles(4 * SLOT, "dim");
    brightness = 4'd15;

    $display("[TB] wrap collision");
    lz_blank = 1'b0;
    runToPhase(10, "coll_align");
    applyStimulus(32'h11111111, 8'h00, "coll_first");
    runToPhase(4 * SLOT - 1, "coll_wait");
    applyStimulus(32'hFFFFFFFF, 8'hFF, "coll_wrap");
    runCycles(2 * 4 * SLOT + 8, "coll_frames");

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      if (i % 200 == 0) begin
        lz_blank   = 1'($urandom);
        brightness = 4'($urandom);
        enable     = ($urandom % 4) != 0;
      end
      hex_data = $urandom;
      dp       = 8'($urandom);
      load     = ($urandom % 10) == 0;
      tick("random");
    end
    load = 1'b0;

    $display("[TB] reset mid-frame");
    enable     = 1'b1;
    brightness = 4'd15;
    lz_blank   = 1'b0;
    runToPhase(4 * SLOT - 1, "rst_align");
    runToPhase(18, "rst_align2");
    applyStimulus(32'hDEADBEEF, 8'hFF, "rst_pending");
    runToPhase(40, "rst_idx2");
    #2 reset_n = 1'b0;
    modelReset();
    #1 checkOutput("async_reset");
    @(negedge clk);
    runCycles(4, "in_reset");
    reset_n = 1'b1;
    runCycles(2 * 4 * SLOT, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
